multiplier_sequencer: RTL and testbench

Control and operand-shifting stage directly upstream of the accumulating `Adder` in the shift-and-add multiplier. On a start request it latches the multiplicand and multiplier, clears the accumulator, and steps through the multiplier bits LSB first over NBits cycles. Each cycle it presents the multiplicand, shifted left by the current step, on `add_operand`, and asserts `add_enable` when that multiplier bit is 1. It then pulses `done` in the cycle the accumulator holds the final product.

---
 rtl/multiplier_sequencer_pkg.sv | 14 +
 rtl/multiplier_sequencer.sv | 80 ++++++++
 tb/tb_multiplier_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/multiplier_sequencer_pkg.sv
// Shared constants and types for the shift-and-add multiplier datapath.
package Parameter_Definitions;

    localparam int NBits  = 8;
    localparam int STEP_W = $clog2(NBits) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/multiplier_sequencer.sv
// Sequencer for the shift-and-add multiplier: walks the multiplier bits LSB
// first and feeds the shifted multiplicand to the accumulating adder.
module multiplier_sequencer
    import Parameter_Definitions::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NBits-1:0]     multiplicand,
    input  logic [NBits-1:0]     multiplier,
    output logic                 busy,
    output logic                 acc_clear,
    output logic                 add_enable,
    output logic [2*NBits-1:0]   add_operand,
    output logic [STEP_W-1:0]    step,
    output logic                 done
);

    seq_state_e               state, next_state;
    logic [2*NBits-1:0]       mcand_reg;
    logic [NBits-1:0]         mplier_reg;
    logic [STEP_W-1:0]        step_reg;
    logic                     last_step;

    assign last_step = (step_reg == STEP_W'(NBits - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            step_reg   <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    // Operands are only captured here; changes while busy are ignored.
                    if (start) begin
                        mcand_reg  <= {{NBits{1'b0}}, multiplicand};
                        mplier_reg <= multiplier;
                    end
                end
                CLEAR: step_reg <= '0;
                RUN: begin
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    step_reg   <= step_reg + STEP_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = CLEAR;
            CLEAR:   next_state = RUN;
            RUN:     if (last_step) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs come from state and registers only, so no input reaches an output.
    always_comb begin
        busy        = (state != IDLE);
        acc_clear   = (state == CLEAR);
        done        = (state == DONE);
        add_enable  = 1'b0;
        add_operand = '0;
        step        = '0;
        if (state == RUN) begin
            add_enable  = mplier_reg[0];
            add_operand = mcand_reg;
            step        = step_reg;
        end
    end

endmodule

// File: tb/tb_multiplier_sequencer.sv
// Self-checking bench: table-driven products plus hand-written corner sequences,
// with a behavioural accumulator standing in for the Adder.
module tb_multiplier_sequencer;

    localparam int N  = 8;
    localparam int SW = $clog2(N) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [N-1:0]      multiplicand = '0;
    logic [N-1:0]      multiplier = '0;
    logic              busy, acc_clear, add_enable, done;
    logic [2*N-1:0]    add_operand;
    logic [SW-1:0]     step;

    logic [2*N:0]      acc;
    int                tests = 0;
    int                fails = 0;
    int                cyc = 0;
    logic [31:0]       sb[$];

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [31:0]  prod;
    } vec_t;

    vec_t vecs[6];

    multiplier_sequencer dut (
        .clk(clk), .rst(rst), .start(start),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .busy(busy), .acc_clear(acc_clear), .add_enable(add_enable),
        .add_operand(add_operand), .step(step), .done(done)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) cyc <= cyc + 1;

    // Adder model: clear on acc_clear, otherwise add the operand when enabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)            acc <= '0;
        else if (acc_clear)  acc <= '0;
        else if (add_enable) acc <= acc + {1'b0, add_operand};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_done_pop(input string name);
        logic [31:0] exp;
        if (sb.size() == 0) begin
            chk({name, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            exp = sb.pop_front();
            chk(name, 32'(acc), exp);
        end
    endtask

    // One complete run with per-step checks; glitch_step >= 0 pulses a
    // competing start with other operands during that RUN step.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [31:0] prod, input int glitch_step);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        sb.push_back(prod);
        tick();
        start = 1'b0;
        chk("clear_pulse", 32'(acc_clear), 32'd1);
        chk("clear_busy", 32'(busy), 32'd1);
        chk("clear_no_add", 32'(add_enable), 32'd0);
        for (int s = 0; s < N; s++) begin
            tick();
            start = 1'b0;
            chk("run_step", 32'(step), 32'(s));
            chk("run_operand", 32'(add_operand), 32'({8'd0, a}) << s);
            chk("run_enable", 32'(add_enable), 32'(b[s]));
            chk("run_no_clear", 32'(acc_clear), 32'd0);
            if (s == glitch_step) begin
                start        = 1'b1;
                multiplicand = 8'd99;
                multiplier   = 8'd77;
            end
        end
        tick();
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_no_add", 32'(add_enable), 32'd0);
        check_done_pop("product");
        tick();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
    endtask

    initial begin
        int dcount;
        int n;
        int last_done;
        vecs[0] = '{8'd13,  8'd11,  32'd143};
        vecs[1] = '{8'd255, 8'd255, 32'd65025};
        vecs[2] = '{8'd0,   8'd200, 32'd0};
        vecs[3] = '{8'd200, 8'd0,   32'd0};
        vecs[4] = '{8'd1,   8'd128, 32'd128};
        vecs[5] = '{8'd170, 8'd85,  32'd14450};

        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_operand", 32'(add_operand), 32'd0);
        chk("rst_outs", 32'({acc_clear, add_enable, done, step}), 32'd0);
        #20;
        rst = 1'b1;
        tick();
        chk("idle_no_start", 32'(busy), 32'd0);

        foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].prod, -1);

        // Start pulsed in cycle 5 (RUN step 3) is ignored and not queued.
        run_op(8'd13, 8'd11, 32'd143, 3);
        start = 1'b0;
        dcount = 0;
        for (int k = 0; k < 15; k++) begin
            if (busy || done) dcount++;
            tick();
        end
        chk("no_queued_run", 32'(dcount), 32'd0);

        // Reset asserted in cycle 6 aborts immediately with no done.
        multiplicand = 8'd200;
        multiplier   = 8'd100;
        start        = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        rst = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_operand", 32'(add_operand), 32'd0);
        chk("abort_outs", 32'({acc_clear, add_enable, done, step}), 32'd0);
        #3;
        rst = 1'b1;
        dcount = 0;
        for (int k = 0; k < 12; k++) begin
            if (done || busy) dcount++;
            tick();
        end
        chk("abort_no_done", 32'(dcount), 32'd0);
        run_op(8'd7, 8'd9, 32'd63, -1);

        // Start held high: back-to-back runs, done every 11 cycles.
        multiplicand = 8'd37;
        multiplier   = 8'd201;
        sb.push_back(32'd7437);
        start = 1'b1;
        last_done = cyc;
        for (int r = 0; r < 3; r++) begin
            n = 0;
            tick();
            while (!done && n < 40) begin
                tick();
                n++;
            end
            if (!done) begin
                chk("held_done_timeout", 32'd0, 32'd1);
                break;
            end
            chk("held_interval", 32'(cyc - last_done), (r == 0) ? 32'd10 : 32'd11);
            last_done = cyc;
            check_done_pop("held_product");
            if (r == 0) begin
                multiplicand = 8'd255;
                multiplier   = 8'd3;
                sb.push_back(32'd765);
            end else if (r == 1) begin
                multiplicand = 8'd19;
                multiplier   = 8'd19;
                sb.push_back(32'd361);
            end else begin
                start = 1'b0;
            end
        end
        tick();
        tick();
        chk("held_stop", 32'(busy), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
